// File: rtl/csi_pkg.sv
// Shared constants for the CSI-2 packet parser: data types, CRC, FSM encoding.
package csi_pkg;

    // Data type codes
    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    // Data types below this value are short packets
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    // CRC-16 x^16+x^12+x^5+1, processed LSB first (reflected form of 0x1021)
    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR1     = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_CRC_HI   = 3'd3,
        ST_WAIT_END = 3'd4
    } csi_state_e;

endpackage

// File: rtl/csi_crc16.sv
// Combinational one-byte update of the CSI-2 payload CRC (LSB-first, reflected).
module csi_crc16
    import csi_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Shift the eight data bits in, bit 0 first
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/csi_packet_parse.sv
// CSI-2 packet parser for a two-lane aligned word stream.
// Handshake: word_in_valid is a qualifier only (no ready); it is high for every
// word of one HS burst and low between bursts. Outputs are registered and appear
// one cycle after the word that produced them; pulses last exactly one cycle.
module csi_packet_parse
    import csi_pkg::*;
#(
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] word_in,
    input  logic        word_in_valid,
    output logic [1:0]  pkt_vc,
    output logic [5:0]  pkt_dt,
    output logic [15:0] pkt_wc,
    output logic        short_valid,
    output logic [15:0] payload_data,
    output logic        payload_valid,
    output logic        payload_last,
    output logic [1:0]  payload_be,
    output logic        pkt_done,
    output logic        crc_err,
    output logic        trunc_err,
    output csi_state_e  fsm_state
);

    csi_state_e  state, state_nxt;
    logic [7:0]  di_q, wc_lo_q, crc_lo_q;
    logic [15:0] remaining_q, crc_q, crc_mid, crc_two, crc_rx;
    logic        is_short;

    logic [1:0]  pkt_vc_d;
    logic [5:0]  pkt_dt_d;
    logic [15:0] pkt_wc_d, payload_data_d;
    logic [1:0]  payload_be_d;
    logic        short_valid_d, payload_valid_d, payload_last_d;
    logic        pkt_done_d, crc_err_d, trunc_err_d;

    assign fsm_state = state;
    assign is_short  = (di_q[5:0] < DT_LONG_MIN);

    // Two byte updates in series: lane0 byte first, then lane1 byte
    csi_crc16 u_crc_lane0 (.crc_in(crc_q),   .data(word_in[15:8]), .crc_out(crc_mid));
    csi_crc16 u_crc_lane1 (.crc_in(crc_mid), .data(word_in[7:0]),  .crc_out(crc_two));

    // Received CRC: low byte travels first, either in this word or held from the last payload word
    assign crc_rx = (state == ST_CRC_HI) ? {word_in[15:8], crc_lo_q}
                                         : {word_in[7:0], word_in[15:8]};

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; a dropped valid mid-packet abandons it
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (word_in_valid) state_nxt = ST_HDR1;
            ST_HDR1:     if (!word_in_valid)  state_nxt = ST_IDLE;
                         else if (is_short)   state_nxt = ST_WAIT_END;
                         else                 state_nxt = ST_PAYLOAD;
            ST_PAYLOAD:  if (!word_in_valid)              state_nxt = ST_IDLE;
                         else if (remaining_q == 16'd1)   state_nxt = ST_CRC_HI;
                         else if (remaining_q == 16'd0)   state_nxt = ST_WAIT_END;
            ST_CRC_HI:   if (!word_in_valid) state_nxt = ST_IDLE;
                         else                state_nxt = ST_WAIT_END;
            ST_WAIT_END: if (!word_in_valid) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Header fields, remaining byte count and running CRC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            di_q        <= '0;
            wc_lo_q     <= '0;
            crc_lo_q    <= '0;
            remaining_q <= '0;
            crc_q       <= CRC_SEED;
        end else if (word_in_valid) begin
            case (state)
                ST_IDLE: begin
                    di_q    <= word_in[15:8];
                    wc_lo_q <= word_in[7:0];
                    crc_q   <= CRC_SEED;
                end
                ST_HDR1: remaining_q <= {word_in[15:8], wc_lo_q};
                ST_PAYLOAD: begin
                    if (remaining_q >= 16'd2) begin
                        remaining_q <= remaining_q - 16'd2;
                        crc_q       <= crc_two;
                    end else if (remaining_q == 16'd1) begin
                        remaining_q <= 16'd0;
                        crc_q       <= crc_mid;
                        crc_lo_q    <= word_in[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: next value of every registered output
    always_comb begin
        pkt_vc_d        = pkt_vc;
        pkt_dt_d        = pkt_dt;
        pkt_wc_d        = pkt_wc;
        short_valid_d   = 1'b0;
        payload_data_d  = '0;
        payload_valid_d = 1'b0;
        payload_last_d  = 1'b0;
        payload_be_d    = '0;
        pkt_done_d      = 1'b0;
        crc_err_d       = 1'b0;
        trunc_err_d     = 1'b0;
        if (!word_in_valid) begin
            trunc_err_d = (state == ST_HDR1) || (state == ST_PAYLOAD) || (state == ST_CRC_HI);
        end else begin
            case (state)
                ST_HDR1: begin
                    pkt_vc_d      = di_q[7:6];
                    pkt_dt_d      = di_q[5:0];
                    pkt_wc_d      = {word_in[15:8], wc_lo_q};
                    short_valid_d = is_short;
                end
                ST_PAYLOAD: begin
                    if (remaining_q != 16'd0) begin
                        payload_valid_d = 1'b1;
                        payload_data_d  = word_in;
                        payload_be_d    = (remaining_q == 16'd1) ? 2'b10 : 2'b11;
                        payload_last_d  = (remaining_q <= 16'd2);
                    end else begin
                        pkt_done_d = 1'b1;
                        crc_err_d  = CHECK_CRC && (crc_rx != crc_q);
                    end
                end
                ST_CRC_HI: begin
                    pkt_done_d = 1'b1;
                    crc_err_d  = CHECK_CRC && (crc_rx != crc_q);
                end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_vc        <= '0;
            pkt_dt        <= '0;
            pkt_wc        <= '0;
            short_valid   <= 1'b0;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            payload_be    <= '0;
            pkt_done      <= 1'b0;
            crc_err       <= 1'b0;
            trunc_err     <= 1'b0;
        end else begin
            pkt_vc        <= pkt_vc_d;
            pkt_dt        <= pkt_dt_d;
            pkt_wc        <= pkt_wc_d;
            short_valid   <= short_valid_d;
            payload_data  <= payload_data_d;
            payload_valid <= payload_valid_d;
            payload_last  <= payload_last_d;
            payload_be    <= payload_be_d;
            pkt_done      <= pkt_done_d;
            crc_err       <= crc_err_d;
            trunc_err     <= trunc_err_d;
        end
    end

endmodule

// File: tb/tb_csi_packet_parse.sv
// Bench for csi_packet_parse: byte-stream model with per-cycle expected queue.
`timescale 1ns/1ps
module tb_csi_packet_parse;
    import csi_pkg::*;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic        sv;
        logic        pv;
        logic [15:0] pd;
        logic [1:0]  be;
        logic        pl;
        logic        done;
        logic        cerr;
        logic        terr;
    } exp_t;

    // Clock / reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [15:0] word_in = '0;
    logic word_in_valid = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] pkt_vc, pkt_vc_n;
    logic [5:0] pkt_dt, pkt_dt_n;
    logic [15:0] pkt_wc, pkt_wc_n, payload_data, payload_data_n;
    logic short_valid, short_valid_n, payload_valid, payload_valid_n;
    logic payload_last, payload_last_n, pkt_done, pkt_done_n;
    logic crc_err, crc_err_n, trunc_err, trunc_err_n;
    logic [1:0] payload_be, payload_be_n;
    logic [2:0] fsm_state, fsm_state_n;

    csi_packet_parse dut (
        .clk(clk), .resetn(resetn), .word_in(word_in), .word_in_valid(word_in_valid),
        .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc), .short_valid(short_valid),
        .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last),
        .payload_be(payload_be), .pkt_done(pkt_done), .crc_err(crc_err), .trunc_err(trunc_err),
        .fsm_state(fsm_state)
    );

    csi_packet_parse #(.CHECK_CRC(1'b0)) dut_nocrc (
        .clk(clk), .resetn(resetn), .word_in(word_in), .word_in_valid(word_in_valid),
        .pkt_vc(pkt_vc_n), .pkt_dt(pkt_dt_n), .pkt_wc(pkt_wc_n), .short_valid(short_valid_n),
        .payload_data(payload_data_n), .payload_valid(payload_valid_n), .payload_last(payload_last_n),
        .payload_be(payload_be_n), .pkt_done(pkt_done_n), .crc_err(crc_err_n), .trunc_err(trunc_err_n),
        .fsm_state(fsm_state_n)
    );

    // Scoreboard state
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    logic [1:0] m_vc = '0;
    logic [5:0] m_dt = '0;
    logic [15:0] m_wc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // CRC reference: MSB-first CCITT on bit-reversed bytes, result bit-reversed
    function automatic logic [15:0] crc_ref(input logic [7:0] b[$], input int from, input int len);
        logic [15:0] c;
        logic [15:0] r;
        logic fb;
        c = 16'hFFFF;
        for (int k = 0; k < len; k++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ b[from + k][j];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        for (int j = 0; j < 16; j++) r[j] = c[15 - j];
        return r;
    endfunction

    // Build a complete long packet (header, payload, CRC) as aligned words
    task automatic make_long(input logic [1:0] vc, input logic [5:0] dt, input logic [7:0] pl[$],
                             output logic [15:0] w[$]);
        logic [7:0] b[$];
        logic [15:0] wc, c;
        wc = 16'(pl.size());
        c = crc_ref(pl, 0, pl.size());
        b.push_back({vc, dt});
        b.push_back(wc[7:0]);
        b.push_back(wc[15:8]);
        b.push_back(8'h00);
        foreach (pl[i]) b.push_back(pl[i]);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        if (b.size() % 2 == 1) b.push_back(8'h00);
        w = {};
        for (int i = 0; i < b.size(); i += 2) w.push_back({b[i], b[i + 1]});
    endtask

    // Model: view the burst as a byte stream and derive one expectation per cycle
    task automatic model_burst(input logic [15:0] w[$], input int gap);
        logic [7:0] b[$];
        exp_t r;
        int n, wc, np, crc_wi;
        bit is_long;
        logic [1:0] old_vc;
        logic [5:0] old_dt;
        logic [15:0] old_wc;
        n = w.size();
        foreach (w[i]) begin
            b.push_back(w[i][15:8]);
            b.push_back(w[i][7:0]);
        end
        old_vc = m_vc; old_dt = m_dt; old_wc = m_wc;
        is_long = 1'b0; wc = 0; np = 0; crc_wi = 0;
        if (n >= 2) begin
            m_vc = b[0][7:6];
            m_dt = b[0][5:0];
            m_wc = {b[2], b[1]};
            is_long = (m_dt >= 6'h10);
            wc = int'(m_wc);
            np = (wc + 1) / 2;
            crc_wi = (wc + 5) / 2;
        end
        for (int i = 0; i < n + gap; i++) begin
            r = '0;
            r.vc = (i == 0) ? old_vc : m_vc;
            r.dt = (i == 0) ? old_dt : m_dt;
            r.wc = (i == 0) ? old_wc : m_wc;
            if (i == 1 && i < n) r.sv = !is_long;
            if (is_long && i >= 2 && (i - 2) < np && i < n) begin
                r.pv = 1'b1;
                r.pd = w[i];
                r.pl = ((i - 2) == np - 1);
                r.be = (wc % 2 == 1 && (i - 2) == np - 1) ? 2'b10 : 2'b11;
            end
            if (is_long && i == crc_wi && i < n) begin
                r.done = 1'b1;
                r.cerr = ({b[wc + 5], b[wc + 4]} != crc_ref(b, 4, wc));
            end
            if (i == n && gap > 0) r.terr = (n == 1) || (is_long && n <= crc_wi);
            exp_q.push_back(r);
        end
    endtask

    // Driver: valid words then idle gap, one word per cycle, driven on negedge
    task automatic drive(input logic [15:0] w[$], input int gap);
        foreach (w[i]) begin
            word_in = w[i];
            word_in_valid = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < gap; i++) begin
            word_in = 16'($urandom_range(0, 65535));
            word_in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_burst(input logic [15:0] w[$], input int gap);
        model_burst(w, gap);
        drive(w, gap);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vc"}, 32'(pkt_vc), 0);
        chk({tag, "_dt"}, 32'(pkt_dt), 0);
        chk({tag, "_wc"}, 32'(pkt_wc), 0);
        chk({tag, "_pulses"}, 32'({short_valid, payload_valid, payload_last, pkt_done, crc_err, trunc_err}), 0);
        chk({tag, "_data_be"}, 32'({payload_data, payload_be}), 0);
        chk({tag, "_state"}, 32'(fsm_state), 0);
    endtask

    // Compare process: one expectation per cycle, sampled 1 ns after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pkt_vc", 32'(pkt_vc), 32'(e.vc));
            chk("pkt_dt", 32'(pkt_dt), 32'(e.dt));
            chk("pkt_wc", 32'(pkt_wc), 32'(e.wc));
            chk("short_valid", 32'(short_valid), 32'(e.sv));
            chk("payload_valid", 32'(payload_valid), 32'(e.pv));
            chk("payload_last", 32'(payload_last), 32'(e.pl));
            chk("pkt_done", 32'(pkt_done), 32'(e.done));
            chk("crc_err", 32'(crc_err), 32'(e.cerr));
            chk("trunc_err", 32'(trunc_err), 32'(e.terr));
            chk("nocrc_pkt_done", 32'(pkt_done_n), 32'(e.done));
            chk("nocrc_crc_err", 32'(crc_err_n), 0);
            if (e.pv) begin
                chk("payload_data", 32'(payload_data), 32'(e.pd));
                chk("payload_be", 32'(payload_be), 32'(e.be));
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        logic [15:0] w[$];
        logic [15:0] p[$];

        repeat (3) @(negedge clk);
        check_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Pin the CRC reference on the standard check string
        pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("pin_crc_check", 32'(crc_ref(pl, 0, 9)), 32'h6F91);

        // Frame start, WC 5, header {DI=00,WC_lo=05},{WC_hi=00,ECC}
        w = {16'h0005, 16'h0000};
        model_burst(w, 1);
        chk("pin_short_sv", 32'(exp_q[1].sv), 1);
        chk("pin_short_wc", 32'(exp_q[1].wc), 32'h0005);
        chk("pin_short_pv", 32'(exp_q[1].pv), 0);
        drive(w, 1);
        // Frame end on VC1 with a trailing word that must be discarded
        run_burst({16'h4134, 16'h1200, 16'hBEEF}, 2);
        run_burst({16'h0000, 16'h0500}, 1);

        // RAW8, WC 4, good CRC
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        make_long(2'd0, DT_RAW8, pl, w);
        model_burst(w, 1);
        chk("pin_wc4_be0", 32'({exp_q[2].pv, exp_q[2].be, exp_q[2].pl}), 32'b1110);
        chk("pin_wc4_last", 32'({exp_q[3].pv, exp_q[3].be, exp_q[3].pl}), 32'b1111);
        chk("pin_wc4_done", 32'({exp_q[4].done, exp_q[4].cerr}), 32'b10);
        drive(w, 1);

        // WC 3: CRC low byte shares the last payload word
        pl = {8'h01, 8'h02, 8'h03};
        make_long(2'd1, DT_RAW8, pl, w);
        model_burst(w, 1);
        chk("pin_wc3_last", 32'({exp_q[3].be, exp_q[3].pl, exp_q[3].done}), 32'b1010);
        chk("pin_wc3_done", 32'({exp_q[4].done, exp_q[4].cerr}), 32'b10);
        drive(w, 1);

        // WC 4 with one payload bit flipped after the CRC was computed
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        make_long(2'd0, DT_RAW8, pl, w);
        w[2] = w[2] ^ 16'h0001;
        model_burst(w, 1);
        chk("pin_flip_cerr", 32'({exp_q[4].done, exp_q[4].cerr}), 32'b11);
        drive(w, 1);

        // WC 8 cut after the first payload word, then a clean packet
        pl = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        make_long(2'd0, DT_RAW8, pl, w);
        p = {w[0], w[1], w[2]};
        model_burst(p, 1);
        chk("pin_trunc", 32'({exp_q[3].terr, exp_q[3].done}), 32'b10);
        drive(p, 1);
        pl = {8'hA5, 8'h5A};
        make_long(2'd2, DT_RAW10, pl, w);
        run_burst(w, 1);

        // Zero word count: CRC word directly after the header
        pl = {};
        make_long(2'd3, DT_RAW8, pl, w);
        run_burst(w, 1);

        // Truncation in HDR1 and in CRC_HI, then an odd-length packet with payload checks
        run_burst({16'h2A10}, 1);
        pl = {8'hAB};
        make_long(2'd0, DT_RAW8, pl, w);
        p = {w[0], w[1], w[2]};
        run_burst(p, 1);
        pl = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        make_long(2'd1, DT_RAW10, pl, w);
        run_burst(w, 3);

        // Asynchronous reset in the middle of a payload
        pl = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        make_long(2'd1, DT_RAW8, pl, w);
        p = {w[0], w[1], w[2]};
        run_burst(p, 0);
        word_in = w[3];
        word_in_valid = 1'b1;
        #2 resetn = 1'b0;
        m_vc = '0; m_dt = '0; m_wc = '0;
        #1 check_zero("midreset");
        repeat (2) @(negedge clk);
        check_zero("heldreset");
        word_in_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        run_burst({16'h8203, 16'h0000}, 1);

        // Largest word count: 32768 payload words, last one half-filled
        pl = {};
        for (int k = 0; k < 65535; k++) pl.push_back(8'(k ^ (k >> 8)));
        make_long(2'd2, DT_RAW8, pl, w);
        run_burst(w, 2);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
